// File: rtl/pulse_driver.sv
// Stretches single-cycle event strobes into fixed-width pulses that survive a
// 5-sample filter, queueing events that arrive while a pulse is in flight.
module pulse_driver #(
    parameter int unsigned HIGH_CYC = 6,
    parameter int unsigned LOW_CYC  = 6,
    parameter int unsigned MAX_PEND = 3,
    parameter int unsigned CNT_W    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pulse_in,
    output logic       dout,
    output logic       busy,
    output logic [1:0] pend,
    output logic       drop
);

    localparam int unsigned PEND_W = 2;
    localparam logic [CNT_W-1:0]  HIGH_LAST = CNT_W'(HIGH_CYC - 1);
    localparam logic [CNT_W-1:0]  LOW_LAST  = CNT_W'(LOW_CYC - 1);
    localparam logic [PEND_W-1:0] PEND_MAX  = PEND_W'(MAX_PEND);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;

    logic gap_end_c;
    logic restart_c;
    logic take_queued_c;
    logic enqueue_c;
    logic full_c;

    // A restart with an empty queue consumes the same-cycle pulse_in instead of enqueueing it.
    assign gap_end_c     = (state == GAP) && (cnt == LOW_LAST);
    assign restart_c     = gap_end_c && ((pend != '0) || pulse_in);
    assign take_queued_c = restart_c && (pend != '0);
    assign enqueue_c     = pulse_in && (state != IDLE) && !(restart_c && (pend == '0));
    assign full_c        = (pend == PEND_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            dout  <= 1'b0;
            busy  <= 1'b0;
            pend  <= '0;
            drop  <= 1'b0;
        end else begin
            drop <= 1'b0;

            // Simultaneous enqueue and consume leaves the count untouched, even when full.
            if (enqueue_c && !take_queued_c) begin
                if (full_c) begin
                    drop <= 1'b1;
                end else begin
                    pend <= pend + PEND_W'(1);
                end
            end else if (!enqueue_c && take_queued_c) begin
                pend <= pend - PEND_W'(1);
            end

            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (pulse_in) begin
                        state <= HIGH;
                        dout  <= 1'b1;
                        busy  <= 1'b1;
                    end
                end
                HIGH: begin
                    if (cnt == HIGH_LAST) begin
                        state <= GAP;
                        dout  <= 1'b0;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                GAP: begin
                    if (gap_end_c) begin
                        cnt <= '0;
                        if (restart_c) begin
                            state <= HIGH;
                            dout  <= 1'b1;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    dout  <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pulse_driver.sv
// Directed and randomized checks of pulse_driver: pulse timing scoreboard,
// queue/drop accounting, async reset and a 5-sample far-end filter model.
module tb_pulse_driver;

    localparam int HIGH = 6;
    localparam int LOW  = 6;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       pulse_in;
    logic       dout;
    logic       busy;
    logic [1:0] pend;
    logic       drop;

    always #5 clk = ~clk;

    pulse_driver #(
        .HIGH_CYC(6),
        .LOW_CYC (6),
        .MAX_PEND(3),
        .CNT_W   (4)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .pulse_in(pulse_in),
        .dout    (dout),
        .busy    (busy),
        .pend    (pend),
        .drop    (drop)
    );

    int         n_cmp = 0;
    int         n_err = 0;
    int         cyc = 0;
    bit [255:0] ev;
    int         exp_q[$];
    bit         use_exp = 1'b1;

    logic       prev;
    logic       have_fall;
    int         rise_c;
    int         fall_c;
    int         n_rise;
    int         n_det;
    int         n_drop;
    int         n_ev;
    logic [4:0] flt;
    logic       det_prev;
    logic       s_dout;
    logic       s_busy;
    logic       s_drop;
    logic [1:0] s_pend;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic clear_mon();
        prev      = 1'b0;
        have_fall = 1'b0;
        flt       = '0;
        det_prev  = 1'b0;
        n_rise    = 0;
        n_det     = 0;
        n_drop    = 0;
        rise_c    = 0;
        fall_c    = 0;
    endtask

    // Leaves the bench just after a rising edge with cycle 0 starting.
    task automatic do_reset();
        pulse_in = 1'b0;
        rst_n    = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        cyc = 0;
        ev  = '0;
        exp_q.delete();
        clear_mon();
    endtask

    // One clock: drive pulse_in for this cycle, sample mid-cycle, then advance.
    task automatic step();
        pulse_in = (cyc < 256) ? ev[cyc[7:0]] : 1'b0;
        @(negedge clk);
        s_dout = dout;
        s_busy = busy;
        s_pend = pend;
        s_drop = drop;
        if (s_drop) n_drop++;
        if (s_dout && !prev) begin
            if (have_fall)
                check($sformatf("gap_ge_low@%0d", cyc), 32'(cyc - fall_c >= LOW), 32'd1);
            rise_c = cyc;
            n_rise++;
        end
        if (!s_dout && prev) begin
            check($sformatf("width@%0d", cyc), 32'(cyc - rise_c), 32'(HIGH));
            if (use_exp) begin
                check($sformatf("pulse_expected@%0d", rise_c), 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0)
                    check($sformatf("rise_cycle#%0d", n_rise), 32'(rise_c), 32'(exp_q.pop_front()));
            end
            fall_c    = cyc;
            have_fall = 1'b1;
        end
        prev = s_dout;
        flt  = {flt[3:0], s_dout};
        if ((&flt) && !det_prev) n_det++;
        det_prev = &flt;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_until(input int n);
        while (cyc < n) step();
    endtask

    // After at(k), the s_* samples belong to cycle k.
    task automatic at(input int k);
        run_until(k + 1);
    endtask

    initial begin
        rst_n    = 1'b1;
        pulse_in = 1'b0;
        #1 rst_n = 1'b0;
        #2;
        check("reset_dout", 32'(dout), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_pend", 32'(pend), 32'd0);
        check("reset_drop", 32'(drop), 32'd0);

        // Single event
        do_reset();
        ev[10] = 1'b1;
        exp_q.push_back(11);
        at(10); check("t1_dout@10", 32'(s_dout), 32'd0); check("t1_busy@10", 32'(s_busy), 32'd0);
        at(11); check("t1_dout@11", 32'(s_dout), 32'd1); check("t1_busy@11", 32'(s_busy), 32'd1);
        at(12); check("t1_pend@12", 32'(s_pend), 32'd0);
        at(16); check("t1_dout@16", 32'(s_dout), 32'd1);
        at(17); check("t1_dout@17", 32'(s_dout), 32'd0); check("t1_busy@17", 32'(s_busy), 32'd1);
        at(22); check("t1_busy@22", 32'(s_busy), 32'd1);
        at(23); check("t1_busy@23", 32'(s_busy), 32'd0);
        run_until(30);
        check("t1_pulses_left", 32'(exp_q.size()), 32'd0);

        // Back-to-back events
        do_reset();
        ev[10] = 1'b1; ev[12] = 1'b1;
        exp_q.push_back(11); exp_q.push_back(23);
        at(12); check("t2_pend@12", 32'(s_pend), 32'd0);
        at(13); check("t2_pend@13", 32'(s_pend), 32'd1);
        at(22); check("t2_dout@22", 32'(s_dout), 32'd0); check("t2_pend@22", 32'(s_pend), 32'd1);
        at(23); check("t2_dout@23", 32'(s_dout), 32'd1); check("t2_pend@23", 32'(s_pend), 32'd0);
        at(34); check("t2_busy@34", 32'(s_busy), 32'd1);
        at(35); check("t2_busy@35", 32'(s_busy), 32'd0);
        run_until(40);
        check("t2_pulses_left", 32'(exp_q.size()), 32'd0);

        // Overflow: fifth event is dropped
        do_reset();
        ev[10] = 1'b1; ev[12] = 1'b1; ev[13] = 1'b1; ev[14] = 1'b1; ev[15] = 1'b1;
        exp_q.push_back(11); exp_q.push_back(23); exp_q.push_back(35); exp_q.push_back(47);
        at(13); check("t3_pend@13", 32'(s_pend), 32'd1);
        at(14); check("t3_pend@14", 32'(s_pend), 32'd2);
        at(15); check("t3_pend@15", 32'(s_pend), 32'd3); check("t3_drop@15", 32'(s_drop), 32'd0);
        at(16); check("t3_pend@16", 32'(s_pend), 32'd3); check("t3_drop@16", 32'(s_drop), 32'd1);
        at(17); check("t3_drop@17", 32'(s_drop), 32'd0);
        at(58); check("t3_busy@58", 32'(s_busy), 32'd1);
        at(59); check("t3_busy@59", 32'(s_busy), 32'd0);
        run_until(65);
        check("t3_pulses_left", 32'(exp_q.size()), 32'd0);
        check("t3_drop_count", 32'(n_drop), 32'd1);

        // Full queue with a new event on the last gap cycle
        do_reset();
        ev[10] = 1'b1; ev[12] = 1'b1; ev[13] = 1'b1; ev[14] = 1'b1; ev[22] = 1'b1;
        exp_q.push_back(11); exp_q.push_back(23); exp_q.push_back(35);
        exp_q.push_back(47); exp_q.push_back(59);
        at(22); check("t4_pend@22", 32'(s_pend), 32'd3);
        at(23); check("t4_pend@23", 32'(s_pend), 32'd3); check("t4_drop@23", 32'(s_drop), 32'd0);
        check("t4_dout@23", 32'(s_dout), 32'd1);
        at(70); check("t4_busy@70", 32'(s_busy), 32'd1);
        at(71); check("t4_busy@71", 32'(s_busy), 32'd0);
        run_until(80);
        check("t4_pulses_left", 32'(exp_q.size()), 32'd0);
        check("t4_drop_count", 32'(n_drop), 32'd0);

        // Asynchronous reset in the middle of a pulse
        do_reset();
        ev[10] = 1'b1; ev[11] = 1'b1; ev[12] = 1'b1;
        run_until(13);
        pulse_in = 1'b0;
        @(negedge clk);
        check("t5_dout_pre", 32'(dout), 32'd1);
        check("t5_pend_pre", 32'(pend), 32'd2);
        #1 rst_n = 1'b0;
        #1;
        check("t5_dout_rst", 32'(dout), 32'd0);
        check("t5_busy_rst", 32'(busy), 32'd0);
        check("t5_pend_rst", 32'(pend), 32'd0);
        do_reset();
        ev[3] = 1'b1;
        exp_q.push_back(4);
        at(4);  check("t5_dout@4", 32'(s_dout), 32'd1);
        at(15); check("t5_busy@15", 32'(s_busy), 32'd1);
        at(16); check("t5_busy@16", 32'(s_busy), 32'd0);
        run_until(25);
        check("t5_pulses_left", 32'(exp_q.size()), 32'd0);

        // Random patterns seen through a 5-FF AND filter
        use_exp = 1'b0;
        for (int p = 0; p < 20; p++) begin
            do_reset();
            n_ev = 0;
            for (int c = 0; c <= 40; c++) begin
                ev[c] = ($urandom_range(0, 3) == 0);
                if (ev[c]) n_ev++;
            end
            run_until(140);
            check($sformatf("rnd%0d_filter_hits", p), 32'(n_det), 32'(n_rise));
            check($sformatf("rnd%0d_pulses", p), 32'(n_rise), 32'(n_ev - n_drop));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
